// File: rtl/gcd_engine.sv
// Iterative GCD engine: subtraction (MODE 0) or binary Stein (MODE 1) algorithm,
// one step per clock, with valid/ready handshakes on both sides and abort.
module gcd_engine #(
   parameter int WIDTH = 16,
   parameter int MODE  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] cycles,
   output logic             zero_in
);

   localparam int KW = $clog2(WIDTH + 1);
   localparam logic [KW-1:0]    K_ZERO   = {KW{1'b0}};
   localparam logic [KW-1:0]    K_ONE    = {{(KW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] a_r, a_s;
   logic [WIDTH-1:0] b_r, b_s;
   logic [KW-1:0]    k_r, k_s;
   logic [WIDTH-1:0] cnt_r, cnt_s;
   logic [WIDTH-1:0] result_r, result_s;
   logic             zero_r, zero_s;
   logic             in_ready_r, out_valid_r;

   // Next-state, datapath step and termination detection
   always_comb begin
      state_s  = state_r;
      a_s      = a_r;
      b_s      = b_r;
      k_s      = k_r;
      cnt_s    = cnt_r;
      result_s = result_r;
      zero_s   = zero_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_s = CALC;
               a_s     = a_in;
               b_s     = b_in;
               k_s     = K_ZERO;
               cnt_s   = W_ZERO;
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            cnt_s = (cnt_r == W_ONES) ? cnt_r : cnt_r + W_ONE;
            if (a_r == W_ZERO) begin
               state_s  = DONE;
               result_s = b_r << k_r;
               zero_s   = (b_r == W_ZERO);
            end else if (b_r == W_ZERO || a_r == b_r) begin
               state_s  = DONE;
               result_s = a_r << k_r;
               zero_s   = 1'b0;
            end else if (MODE == 0) begin
               if (a_r > b_r) begin
                  a_s = a_r - b_r;
               end else begin
                  b_s = b_r - a_r;
               end
            end else begin
               // Stein: strip common factors of two into k, then odd/odd subtract
               case ({a_r[0], b_r[0]})
                  2'b00: begin
                     a_s = a_r >> 1;
                     b_s = b_r >> 1;
                     k_s = k_r + K_ONE;
                  end
                  2'b01: a_s = a_r >> 1;
                  2'b10: b_s = b_r >> 1;
                  default: begin
                     if (a_r > b_r) begin
                        a_s = a_r - b_r;
                     end else begin
                        b_s = b_r - a_r;
                     end
                  end
               endcase
            end
         end
         DONE: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
      if (abort) begin
         state_s = IDLE;
      end else begin
         state_s = state_s;
      end
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         a_r         <= W_ZERO;
         b_r         <= W_ZERO;
         k_r         <= K_ZERO;
         cnt_r       <= W_ZERO;
         result_r    <= W_ZERO;
         zero_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         a_r         <= a_s;
         b_r         <= b_s;
         k_r         <= k_s;
         cnt_r       <= cnt_s;
         result_r    <= result_s;
         zero_r      <= zero_s;
         in_ready_r  <= (state_s == IDLE);
         out_valid_r <= (state_s == DONE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign cycles    = cnt_r;
   assign zero_in   = zero_r;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: one subtraction and one Stein instance fed the same jobs,
// checked each output cycle against an arithmetic GCD model plus literal values.
module tb_gcd_engine;
   localparam int W = 16;
   localparam int CMAX = 65535;

   logic clk = 1'b0;
   logic rst_n, in_valid, abort, out_ready;
   logic [W-1:0] a_in, b_in;
   logic ir0, ov0, zr0, ir1, ov1, zr1;
   logic [W-1:0] res0, cyc0, res1, cyc1;

   always #5 clk = ~clk;

   gcd_engine #(.WIDTH(W), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
      .a_in(a_in), .b_in(b_in), .abort(abort), .out_valid(ov0),
      .out_ready(out_ready), .result(res0), .cycles(cyc0), .zero_in(zr0));

   gcd_engine #(.WIDTH(W), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
      .a_in(a_in), .b_in(b_in), .abort(abort), .out_valid(ov1),
      .out_ready(out_ready), .result(res1), .cycles(cyc1), .zero_in(zr1));

   wire [1:0] ov_v = {ov1, ov0};
   wire [1:0] ir_v = {ir1, ir0};
   wire [1:0] zr_v = {zr1, zr0};
   logic [W-1:0] res_v [2];
   logic [W-1:0] cyc_v [2];
   assign res_v[0] = res0;
   assign res_v[1] = res1;
   assign cyc_v[0] = cyc0;
   assign cyc_v[1] = cyc1;

   int vectors = 0;
   int errors  = 0;
   int edge_cnt = 0;
   int acc_edge = 0;
   int job_seq = 0;
   logic [1:0] exp_pend = 2'b00;
   int exp_res [2];
   int exp_cyc [2];
   int exp_lat [2];
   logic exp_zero [2];
   int done_seq [2] = '{0, 0};
   int seen_seq [2] = '{0, 0};
   int cap_res [2];
   int cap_cyc [2];
   int cap_zero [2];

   // ---------------- reference model ----------------
   function automatic int gcd_ref(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int steps_ref(input int mode, input int a, input int b);
      int n;
      n = 1;
      while (!(a == 0 || b == 0 || a == b)) begin
         if (mode == 1 && a % 2 == 0 && b % 2 == 0) begin
            a = a / 2;
            b = b / 2;
         end else if (mode == 1 && a % 2 == 0) begin
            a = a / 2;
         end else if (mode == 1 && b % 2 == 0) begin
            b = b / 2;
         end else if (a > b) begin
            a = a - b;
         end else begin
            b = b - a;
         end
         n++;
      end
      return n;
   endfunction

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Compare process: every cycle an output is presented
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ov_v[i]) begin
            vectors++;
            if (!exp_pend[i] || done_seq[i] == job_seq) begin
               errors++;
               $display("FAIL spurious_out dut%0d: out_valid=1 result=%0d, required out_valid=0", i, res_v[i]);
            end else begin
               if (res_v[i] !== W'(exp_res[i]) || cyc_v[i] !== W'(exp_cyc[i]) ||
                   zr_v[i] !== exp_zero[i] || ir_v[i] !== 1'b0) begin
                  errors++;
                  $display("FAIL out_check dut%0d: got result=%0d cycles=%0d zero_in=%0d in_ready=%0d, required %0d/%0d/%0d/0",
                           i, res_v[i], cyc_v[i], zr_v[i], ir_v[i], exp_res[i], exp_cyc[i], exp_zero[i]);
               end
               if (seen_seq[i] != job_seq) begin
                  seen_seq[i] = job_seq;
                  vectors++;
                  if (edge_cnt - acc_edge != exp_lat[i]) begin
                     errors++;
                     $display("FAIL latency dut%0d: got %0d edges, required %0d", i, edge_cnt - acc_edge, exp_lat[i]);
                  end
               end
               cap_res[i]  = int'(res_v[i]);
               cap_cyc[i]  = int'(cyc_v[i]);
               cap_zero[i] = int'(zr_v[i]);
               if (out_ready) done_seq[i] = job_seq;
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic check_val(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic start_job(input int a, input int b);
      int n;
      n = 0;
      while (!(ir0 && ir1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val("in_ready_before_job", int'(ir0 && ir1), 1);
      for (int i = 0; i < 2; i++) begin
         exp_res[i]  = gcd_ref(a, b);
         exp_lat[i]  = steps_ref(i, a, b);
         exp_cyc[i]  = (exp_lat[i] > CMAX) ? CMAX : exp_lat[i];
         exp_zero[i] = (a == 0 && b == 0);
      end
      job_seq++;
      exp_pend = 2'b11;
      a_in = W'(a);
      b_in = W'(b);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_edge = edge_cnt;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!(done_seq[0] == job_seq && done_seq[1] == job_seq) && n < 70000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n >= 70000) begin
         errors++;
         $display("FAIL job_timeout: done dut0=%0d dut1=%0d, required both", int'(done_seq[0] == job_seq), int'(done_seq[1] == job_seq));
      end
      @(negedge clk);
   endtask

   task automatic run_job(input int a, input int b);
      start_job(a, b);
      wait_done();
   endtask

   task automatic check_idle(input string name, input int want_zero_data);
      check_val({name, "_in_ready"}, int'({ir1, ir0}), 3);
      check_val({name, "_out_valid"}, int'({ov1, ov0}), 0);
      if (want_zero_data != 0) begin
         check_val({name, "_result"}, int'(res0) + int'(res1), 0);
         check_val({name, "_cycles"}, int'(cyc0) + int'(cyc1), 0);
         check_val({name, "_zero_in"}, int'({zr1, zr0}), 0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      in_valid = 1'b1;
      a_in = 16'd9;
      b_in = 16'd6;
      abort = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("reset", 1);
      in_valid = 1'b0;
      rst_n = 1'b1;

      run_job(143, 78);
      check_val("m0_143_78_result", cap_res[0], 13);
      check_val("m0_143_78_cycles", cap_cyc[0], 7);
      check_val("m0_143_78_zero", cap_zero[0], 0);
      check_val("m1_143_78_result", cap_res[1], 13);
      check_val("m1_143_78_cycles", cap_cyc[1], 8);

      run_job(48, 18);
      check_val("m1_48_18_result", cap_res[1], 6);
      check_val("m1_48_18_cycles", cap_cyc[1], 7);
      check_val("m0_48_18_result", cap_res[0], 6);

      run_job(0, 5);
      check_val("a0_b5_result", cap_res[0], 5);
      check_val("a0_b5_cycles", cap_cyc[1], 1);

      run_job(0, 0);
      check_val("zero_zero_result", cap_res[1], 0);
      check_val("zero_zero_flag", cap_zero[0] + cap_zero[1], 2);
      check_val("zero_zero_cycles", cap_cyc[0], 1);

      run_job(5, 0);
      run_job(7, 7);
      run_job(32768, 16384);
      check_val("m1_shift_result", cap_res[1], 16384);
      run_job(1000, 1);
      run_job(12, 8);

      // Back-pressure: result held while out_ready is low, in_valid ignored
      out_ready = 1'b0;
      start_job(48, 18);
      for (int n = 0; n < 100 && !(seen_seq[0] == job_seq && seen_seq[1] == job_seq); n++) @(negedge clk);
      check_val("hold_both_valid", int'({ov1, ov0}), 3);
      a_in = 16'd9;
      b_in = 16'd3;
      for (int n = 0; n < 10; n++) begin
         in_valid = n[0];
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_val("hold_still_valid", int'({ov1, ov0}), 3);
      out_ready = 1'b1;
      wait_done();
      check_idle("after_release", 0);

      // Abort during the third CALC cycle
      start_job(143, 78);
      @(posedge clk);
      @(posedge clk);
      #1;
      abort = 1'b1;
      exp_pend = 2'b00;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check_idle("after_abort", 0);
      repeat (15) @(negedge clk);
      check_idle("abort_quiet", 0);

      // Reset pulse in the middle of a job
      start_job(100, 75);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      exp_pend = 2'b00;
      #1;
      check_idle("mid_reset", 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_idle("reset_quiet", 0);

      run_job(143, 78);
      check_val("post_reset_m0_result", cap_res[0], 13);
      check_val("post_reset_m0_cycles", cap_cyc[0], 7);
      check_val("post_reset_m1_cycles", cap_cyc[1], 8);

      run_job(65535, 1);
      check_val("sat_m0_result", cap_res[0], 1);
      check_val("sat_m0_cycles", cap_cyc[0], 65535);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
